pwl_lit: RTL

PWL_LIT -- requirements
Module: pwl_lit

---
 rtl/pwl_lit_pkg.sv | 28 ++
 rtl/pwl_lit_seg_sel.sv | 32 +++
 rtl/pwl_lit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pwl_lit_pkg.sv
// pwl_lit_pkg
// Shared definitions for the piecewise-linear lookup block:
//   - default widths and segment count
//   - cfg_sel encodings for the table write port
//   - identity constants loaded into the tables on reset
package pwl_lit_pkg;

  // Default widths: sample Q1.8, coefficients Q3.16, result Q0.16
  localparam int IN_W_DEFAULT   = 9;
  localparam int COEF_W_DEFAULT = 19;
  localparam int OUT_W_DEFAULT  = 16;
  localparam int NSEG_DEFAULT   = 10;

  // Which table a cfg write targets
  typedef enum logic [1:0] {
    CFG_BP    = 2'd0,
    CFG_SLOPE = 2'd1,
    CFG_OFF   = 2'd2,
    CFG_NONE  = 2'd3
  } cfg_sel_e;

  // Identity table contents.
  // A slope of 1.0 in Q3.16 times a Q1.8 sample, shifted right by 8,
  // lands the sample directly in Q0.16.
  localparam logic [31:0] SLOPE_IDENTITY = 32'h0001_0000;
  localparam logic [31:0] OFF_IDENTITY   = 32'h0000_0000;

endpackage

// File: rtl/pwl_lit_seg_sel.sv
// pwl_lit_seg_sel
// Combinational priority comparator that picks the active segment.
// The result is the highest index k with data >= bp[k]. bp[0] is always
// 0, so segment 0 is the fallback when no other breakpoint matches.
// Ports:
//   data : sample being classified
//   bp   : breakpoint table, one entry per segment
//   seg  : selected segment index
module pwl_lit_seg_sel
  import pwl_lit_pkg::*;
#(
  parameter int IN_W = IN_W_DEFAULT,
  parameter int NSEG = NSEG_DEFAULT,
  parameter int AW   = $clog2(NSEG)
) (
  input  logic [IN_W-1:0] data,
  input  logic [IN_W-1:0] bp [NSEG],
  output logic [AW-1:0]   seg
);

  // Later indices override earlier ones. This lets a non-monotonic
  // table resolve to the highest matching index.
  always_comb begin
    seg = '0;
    for (int k = 1; k < NSEG; k++) begin
      if (data >= bp[k]) begin
        seg = AW'(k);
      end
    end
  end

endmodule

// File: rtl/pwl_lit.sv
// pwl_lit
// Piecewise-linear function evaluator with a programmable segment table.
// Each sample selects a segment k. The block then computes
//   r = ((in_data * slope[k]) >> 8) - off[k]
// and saturates the result to the unsigned OUT_W output range.
// The pipeline has two stages:
//   - stage 1 captures the sample and the coefficients of its segment
//   - stage 2 holds the saturated result
// Both stages freeze while the output is stalled.
// Ports:
//   clk, rst                           clock, async active-high reset
//   in_valid/in_ready/in_data          sample stream
//   out_valid/out_ready/out_data       result stream
//   cfg_we/cfg_sel/cfg_addr/cfg_wdata  table write port
//   sat_clr, sat_cnt                   saturation counter (PWL_LIT_SATCNT_EN only)
// Optional feature macro: PWL_LIT_SATCNT_EN
module pwl_lit
  import pwl_lit_pkg::*;
#(
  parameter int IN_W   = IN_W_DEFAULT,
  parameter int COEF_W = COEF_W_DEFAULT,
  parameter int OUT_W  = OUT_W_DEFAULT,
  parameter int NSEG   = NSEG_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_sel,
  input  logic [$clog2(NSEG)-1:0] cfg_addr,
  input  logic [COEF_W-1:0]       cfg_wdata
`ifdef PWL_LIT_SATCNT_EN
  ,
  input  logic                    sat_clr,
  output logic [15:0]             sat_cnt
`endif
);

  localparam int AW = $clog2(NSEG);
  localparam int PW = IN_W + COEF_W;
  localparam int SW = COEF_W + 2;
  localparam logic signed [SW-1:0] OUT_MAX = (SW'(1) << OUT_W) - SW'(1);

  logic [IN_W-1:0]   bp    [NSEG];
  logic [COEF_W-1:0] slope [NSEG];
  logic [COEF_W-1:0] off   [NSEG];

  logic [AW-1:0] seg;
  logic          stall;
  logic          addr_ok;

  logic              s1_valid;
  logic [IN_W-1:0]   s1_data;
  logic [COEF_W-1:0] s1_slope;
  logic [COEF_W-1:0] s1_off;

  logic [PW-1:0]        prod;
  logic signed [SW-1:0] diff;
  logic                 sat_hi;
  logic                 sat_lo;
  logic [OUT_W-1:0]     sat_val;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // The extra leading bit keeps the bound check correct when NSEG is a
  // power of two and NSEG itself does not fit in cfg_addr.
  assign addr_ok = ({1'b0, cfg_addr} < (AW+1)'(NSEG));

  pwl_lit_seg_sel #(
    .IN_W (IN_W),
    .NSEG (NSEG),
    .AW   (AW)
  ) u_seg_sel (
    .data (in_data),
    .bp   (bp),
    .seg  (seg)
  );

  // Table storage. A write lands on the clock edge, so a sample
  // accepted on that same edge still sees the old entry. bp[0] stays
  // pinned to 0, which guarantees that some segment always matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        bp[k]    <= (k == 0) ? '0 : '1;
        slope[k] <= COEF_W'(SLOPE_IDENTITY);
        off[k]   <= COEF_W'(OFF_IDENTITY);
      end
    end else if (cfg_we && addr_ok) begin
      case (cfg_sel_e'(cfg_sel))
        CFG_BP: begin
          if (cfg_addr != '0) begin
            bp[cfg_addr] <= cfg_wdata[IN_W-1:0];
          end
        end
        CFG_SLOPE: slope[cfg_addr] <= cfg_wdata;
        CFG_OFF:   off[cfg_addr]   <= cfg_wdata;
        default:   ;
      endcase
    end
  end

  // Stage 1 captures the coefficients along with the sample. A later
  // table write therefore cannot disturb a sample that is already in
  // flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_slope <= '0;
      s1_off   <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data  <= in_data;
        s1_slope <= slope[seg];
        s1_off   <= off[seg];
      end
    end
  end

  // The shifted product needs at most PW-8 bits, which is fewer than
  // SW. Zero-extending it into SW bits keeps it non-negative, so a
  // negative difference can only come from the offset.
  assign prod = PW'(s1_data) * PW'(s1_slope);
  assign diff = $signed(SW'(prod >> 8)) - $signed(SW'(s1_off));

  assign sat_lo  = diff[SW-1];
  assign sat_hi  = !diff[SW-1] && (diff > OUT_MAX);
  assign sat_val = sat_lo ? '0 : (sat_hi ? '1 : diff[OUT_W-1:0]);

  // Stage 2: saturated result register, which drives the output port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_val;
      end
    end
  end

`ifdef PWL_LIT_SATCNT_EN
  // Counts each clamped result as it moves into stage 2. The counter
  // sticks at its maximum value, and a clear beats a simultaneous
  // increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (s1_valid && !stall && (sat_hi || sat_lo) && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule
